pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Sequences the five-stage MIPS pipeline around the decode stage. Each cycle it decides whether the front end advances, stalls for a load-use hazard, or flushes for a redirect, and it freezes the whole pipeline while data memory is not ready. It drives the PC, IF/ID and ID/EX write and flush controls and keeps saturating stall and flush event counters. It has no datapath of its own; it consumes register indices and control bits already produced by decode and execute.

## Interface
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..7.
- CNT_WIDTH, 16: width of the event counters.

- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ID_Rs  in  5  rs field of the instruction in decode.
- ID_Rt  in  5  rt field of the instruction in decode.
- ID_UsesRt  in  1  decode instruction reads rt: R-type, store or branch.
- EX_MemRead  in  1  instruction in execute is a load.
- EX_WriteRegister  in  5  destination register of the instruction in execute.
- EX_BranchTaken  in  1  branch resolved taken in execute this cycle.
- ID_JumpControl  in  1  jump decoded in decode this cycle.
- MemReady  in  1  data memory can complete this cycle.
- PCWrite  out  1  PC register loads its next value.
- IFID_Write  out  1  IF/ID register loads.
- IFID_Flush  out  1  IF/ID register is cleared to a NOP.
- IDEX_Flush  out  1  ID/EX register is cleared to a bubble.
- Freeze  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- State  out  2  current state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT.
- StallCount  out  CNT_WIDTH  cycles in which PCWrite was 0 because of a stall or freeze.
- FlushCount  out  CNT_WIDTH  cycles in which IFID_Flush was 1.

## Operation
- A load-use hazard exists when all of the following hold:
  - EX_MemRead is 1;
  - EX_WriteRegister is not 0;
  - EX_WriteRegister equals ID_Rs, or ID_UsesRt is 1 and EX_WriteRegister equals ID_Rt.
- The rs comparison is always made. This is conservative: it can produce a false stall for J-type instructions.
- Control outputs are combinational from State, the internal stall counter and the inputs. State and the counters are registered.
- Decision order in RUN and MEM_WAIT, highest priority first:
  1. MemReady is 0: Freeze=1, PCWrite=0, IFID_Write=0, no flushes. Next state MEM_WAIT.
  2. EX_BranchTaken: PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1. Next state RUN.
  3. ID_JumpControl: PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=0. Next state RUN.
  4. Load-use hazard: PCWrite=0, IFID_Write=0, IDEX_Flush=1.
     - LOAD_STALL_CYCLES is 1: next state RUN.
     - Otherwise: stall counter loads LOAD_STALL_CYCLES-1 and next state is LOAD_STALL.
  5. None of the above: PCWrite=1, IFID_Write=1, no flush, Freeze=0. Next state RUN.
- LOAD_STALL:
  - Outputs: PCWrite=0, IFID_Write=0, IDEX_Flush=1.
  - Branch, jump and hazard inputs are ignored.
  - Each cycle the stall counter decrements. When it decrements from 1, next state is RUN.
  - If MemReady is 0: Freeze=1 and IDEX_Flush=0, the stall counter holds, and the state stays LOAD_STALL.
- MEM_WAIT with MemReady=1 applies rules 2 to 5 in the same cycle. Exit from a freeze therefore costs no extra cycle.
- Counters:
  - StallCount increments in every non-reset cycle with PCWrite=0.
  - FlushCount increments in every non-reset cycle with IFID_Flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset is synchronous. Reset asserted at edge N gives, after edge N:
  - State=RUN;
  - stall counter 0;
  - StallCount=0, FlushCount=0.
- While reset is high, outputs are forced to PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, Freeze=0. Counters do not increment.
- Reset in LOAD_STALL or MEM_WAIT abandons that state. There is no residual stall after reset deasserts.
- A load-use hazard seen in cycle N produces bubbles in cycles N to N+LOAD_STALL_CYCLES-1, not counting freeze cycles. The front end advances in cycle N+LOAD_STALL_CYCLES.
- A branch or jump redirect takes effect in the cycle it is asserted, with a penalty of one flushed slot. A simultaneous load-use hazard is discarded, because the dependent instruction is itself flushed.
- Freeze always dominates. No flush is issued in a cycle with Freeze=1.

## Test plan
- Reset: drive reset for 2 cycles with MemReady=1 -> during reset PCWrite=0, IFID_Flush=1, IDEX_Flush=1; after release State=0, PCWrite=1, both counters 0.
- Load-use: EX_MemRead=1, EX_WriteRegister=8, ID_Rs=8 for one cycle -> PCWrite=0, IDEX_Flush=1 for exactly 1 cycle, StallCount=1.
  - Repeat with ID_Rt=8, ID_Rs=9, ID_UsesRt=0 -> no stall.
  - Repeat with EX_WriteRegister=0 -> no stall.
- LOAD_STALL_CYCLES=3: one hazard cycle -> 3 consecutive PCWrite=0 cycles; State=1 in cycles 2 and 3; RUN in cycle 4; StallCount=3.
- Branch taken together with a hazard (EX_BranchTaken=1, EX_MemRead=1, EX_WriteRegister=ID_Rs=5) -> IFID_Flush=IDEX_Flush=1, PCWrite=1; FlushCount +1, StallCount unchanged.
- LOAD_STALL_CYCLES=3, MemReady=0 for 4 cycles starting in the second bubble -> Freeze=1 for 4 cycles with no flush; 2 bubbles remain afterwards; StallCount=7 at the end.
- CNT_WIDTH=4, 20 consecutive jumps -> FlushCount holds at 15 and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Front-end sequencing for the five-stage pipeline: advance, load-use stall, redirect flush, memory freeze.
// Latency: control outputs are combinational from state and inputs; state and counters update on the next edge.
// Backpressure: MemReady=0 freezes every stage and holds any pending stall count until memory is ready.
module pipeline_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic                 ID_UsesRt,
  input  logic                 EX_MemRead,
  input  logic [4:0]           EX_WriteRegister,
  input  logic                 EX_BranchTaken,
  input  logic                 ID_JumpControl,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IFID_Write,
  output logic                 IFID_Flush,
  output logic                 IDEX_Flush,
  output logic                 Freeze,
  output logic [1:0]           State,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  // Remaining bubbles after the one issued in the hazard cycle itself.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [2:0]           stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
  logic                 load_use_hazard;

  // rs is always compared (conservative for J-type); rt only when decode actually reads it.
  assign load_use_hazard = EX_MemRead && (EX_WriteRegister != 5'd0) &&
                           ((EX_WriteRegister == ID_Rs) ||
                            (ID_UsesRt && (EX_WriteRegister == ID_Rt)));

  // Next-state and control decode; freeze dominates, then redirects, then load-use stall.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    Freeze      = 1'b0;

    if (reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      state_d     = RUN;
      stall_cnt_d = 3'd0;
    end else if (state_q == LOAD_STALL) begin
      // Redirect and hazard inputs are ignored until the bubbles are drained.
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      if (!MemReady) begin
        Freeze = 1'b1;
      end else begin
        IDEX_Flush = 1'b1;
        if (stall_cnt_q <= 3'd1) begin
          stall_cnt_d = 3'd0;
          state_d     = RUN;
        end else begin
          stall_cnt_d = stall_cnt_q - 3'd1;
        end
      end
    end else begin
      // RUN and MEM_WAIT share the same decision; leaving a freeze costs no extra cycle.
      if (!MemReady) begin
        Freeze     = 1'b1;
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        state_d    = MEM_WAIT;
      end else if (EX_BranchTaken) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
        state_d    = RUN;
      end else if (ID_JumpControl) begin
        IFID_Flush = 1'b1;
        state_d    = RUN;
      end else if (load_use_hazard) begin
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
        if (LOAD_STALL_CYCLES <= 1) begin
          state_d = RUN;
        end else begin
          stall_cnt_d = STALL_RELOAD;
          state_d     = LOAD_STALL;
        end
      end else begin
        state_d = RUN;
      end
    end
  end

  // Saturating event counters; reset clearing is applied in the register block.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!PCWrite && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
    if (IFID_Flush && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_WIDTH'(1);
    end
  end

  // State, bubble counter and event counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      stall_cnt_q   <= 3'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign State      = state_q;
  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EX_WriteRegister;
  logic       ID_UsesRt, EX_MemRead, EX_BranchTaken, ID_JumpControl, MemReady;

  // u_a: one bubble per hazard; u_b: three bubbles; u_c: 4-bit counters.
  logic        a_pcw, a_ifw, a_iff, a_idf, a_frz;
  logic [1:0]  a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_pcw, b_ifw, b_iff, b_idf, b_frz;
  logic [1:0]  b_st;
  logic [15:0] b_sc, b_fc;
  logic        c_pcw, c_ifw, c_iff, c_idf, c_frz;
  logic [1:0]  c_st;
  logic [3:0]  c_sc, c_fc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(16)) u_a (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .EX_BranchTaken(EX_BranchTaken), .ID_JumpControl(ID_JumpControl), .MemReady(MemReady),
    .PCWrite(a_pcw), .IFID_Write(a_ifw), .IFID_Flush(a_iff), .IDEX_Flush(a_idf),
    .Freeze(a_frz), .State(a_st), .StallCount(a_sc), .FlushCount(a_fc));

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_WIDTH(16)) u_b (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .EX_BranchTaken(EX_BranchTaken), .ID_JumpControl(ID_JumpControl), .MemReady(MemReady),
    .PCWrite(b_pcw), .IFID_Write(b_ifw), .IFID_Flush(b_iff), .IDEX_Flush(b_idf),
    .Freeze(b_frz), .State(b_st), .StallCount(b_sc), .FlushCount(b_fc));

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(4)) u_c (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .EX_BranchTaken(EX_BranchTaken), .ID_JumpControl(ID_JumpControl), .MemReady(MemReady),
    .PCWrite(c_pcw), .IFID_Write(c_ifw), .IFID_Flush(c_iff), .IDEX_Flush(c_idf),
    .Freeze(c_frz), .State(c_st), .StallCount(c_sc), .FlushCount(c_fc));

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one cycle; inputs change 1ns after the edge, checks happen 3ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    reset = 1'b0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; EX_MemRead = 1'b0;
    EX_WriteRegister = 5'd0; EX_BranchTaken = 1'b0; ID_JumpControl = 1'b0; MemReady = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    step();

    // Reset for two cycles
    reset = 1'b1;
    settle();
    chk("rst_pcw", a_pcw, 0);
    chk("rst_ifw", a_ifw, 0);
    chk("rst_iff", a_iff, 1);
    chk("rst_idf", a_idf, 1);
    chk("rst_frz", a_frz, 0);
    step(); step();
    reset = 1'b0;
    settle();
    chk("rel_state", a_st, 0);
    chk("rel_pcw", a_pcw, 1);
    chk("rel_sc", a_sc, 0);
    chk("rel_fc", a_fc, 0);
    step();

    // Single-cycle load-use on rs
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_Rs = 5'd8;
    settle();
    chk("lu_pcw", a_pcw, 0);
    chk("lu_ifw", a_ifw, 0);
    chk("lu_idf", a_idf, 1);
    step();
    idle();
    settle();
    chk("lu_after_pcw", a_pcw, 1);
    chk("lu_after_idf", a_idf, 0);
    chk("lu_sc", a_sc, 1);
    chk("lu_state", a_st, 0);

    // rt match but rt not used: no stall
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_Rt = 5'd8; ID_Rs = 5'd9; ID_UsesRt = 1'b0;
    settle();
    chk("rt_unused_pcw", a_pcw, 1);
    // Destination $0 never stalls
    EX_WriteRegister = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1;
    settle();
    chk("r0_pcw", a_pcw, 1);
    // rt used and matching: stall
    EX_WriteRegister = 5'd8; ID_Rt = 5'd8; ID_Rs = 5'd9; ID_UsesRt = 1'b1;
    settle();
    chk("rt_used_pcw", a_pcw, 0);
    step();
    idle();
    settle();
    chk("rt_used_sc", a_sc, 2);

    // Three-bubble stall; jump during the stall is ignored
    do_reset();
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_Rs = 5'd8;
    settle();
    chk("ls3_c1_pcw", b_pcw, 0);
    chk("ls3_c1_state", b_st, 0);
    step();
    idle();
    ID_JumpControl = 1'b1;
    settle();
    chk("ls3_c2_pcw", b_pcw, 0);
    chk("ls3_c2_state", b_st, 1);
    chk("ls3_c2_iff", b_iff, 0);
    chk("ls3_c2_idf", b_idf, 1);
    step();
    idle();
    settle();
    chk("ls3_c3_pcw", b_pcw, 0);
    chk("ls3_c3_state", b_st, 1);
    step();
    settle();
    chk("ls3_c4_pcw", b_pcw, 1);
    chk("ls3_c4_state", b_st, 0);
    chk("ls3_sc", b_sc, 3);

    // Branch with a simultaneous hazard: redirect wins
    do_reset();
    EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_WriteRegister = 5'd5; ID_Rs = 5'd5;
    settle();
    chk("br_iff", a_iff, 1);
    chk("br_idf", a_idf, 1);
    chk("br_pcw", a_pcw, 1);
    step();
    idle();
    ID_JumpControl = 1'b1;
    settle();
    chk("br_fc", a_fc, 1);
    chk("br_sc", a_sc, 0);
    chk("jmp_iff", a_iff, 1);
    chk("jmp_idf", a_idf, 0);
    step();
    idle();
    settle();
    chk("jmp_fc", a_fc, 2);

    // Freeze from RUN blocks a branch, then branch exits MEM_WAIT immediately
    MemReady = 1'b0; EX_BranchTaken = 1'b1;
    settle();
    chk("mw_frz", a_frz, 1);
    chk("mw_iff", a_iff, 0);
    chk("mw_pcw", a_pcw, 0);
    step();
    MemReady = 1'b1;
    settle();
    chk("mw_state", a_st, 2);
    chk("mw_exit_iff", a_iff, 1);
    chk("mw_exit_pcw", a_pcw, 1);
    step();
    idle();
    settle();
    chk("mw_exit_state", a_st, 0);

    // Freeze for 4 cycles during the second bubble of a three-bubble stall
    do_reset();
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_Rs = 5'd8;
    step();
    idle();
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("frz%0d_frz", i), b_frz, 1);
      chk($sformatf("frz%0d_idf", i), b_idf, 0);
      chk($sformatf("frz%0d_state", i), b_st, 1);
      step();
    end
    MemReady = 1'b1;
    settle();
    chk("frz_b2_pcw", b_pcw, 0);
    chk("frz_b2_idf", b_idf, 1);
    chk("frz_b2_frz", b_frz, 0);
    step();
    settle();
    chk("frz_b3_pcw", b_pcw, 0);
    chk("frz_b3_state", b_st, 1);
    step();
    settle();
    chk("frz_end_pcw", b_pcw, 1);
    chk("frz_end_sc", b_sc, 7);

    // Reset abandons LOAD_STALL
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_Rs = 5'd8;
    step();
    do_reset();
    settle();
    chk("rst_ls_state", b_st, 0);
    chk("rst_ls_pcw", b_pcw, 1);

    // Saturation of a 4-bit flush counter
    ID_JumpControl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 15) begin
        settle();
        chk("sat15_fc", c_fc, 15);
      end
      step();
    end
    idle();
    settle();
    chk("sat20_fc", c_fc, 15);
    chk("sat20_sc", c_sc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
